id_ex_hazard_stage: RTL and testbench

- ID/EX pipeline register plus load-use hazard detection for the RV32IF core.
- Sits between decode and execute, and directly feeds the forwarding unit's id_ex_rs1, id_ex_rs2 and id_ex_opcode inputs.
- Inserts a single bubble on a load-use dependency, holds the whole stage while a multi-cycle FPU op is busy, and squashes on a branch or jump flush.
- Power-aware: bubbles and flushes clear only control fields; data fields hold their value.

---
 rtl/id_ex_hazard_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage
//   ID/EX pipeline register with load-use hazard detection for the RV32IF core.
//   A load-use dependency inserts one bubble. A busy multi-cycle EX op (FPU
//   div/sqrt) freezes the stage. A branch/jump flush squashes it. Bubbles and
//   flushes clear only the control fields. The data fields, rs1 and rs2 keep
//   their old value so the operand buses do not toggle.
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   id_*                       decode-slot instruction (valid, pc, opcode,
//                              indices, operands, immediate, control bits)
//   ex_busy                    multi-cycle EX op not finished
//   flush                      branch/jump redirect from EX
//   id_ex_*                    registered instruction; feeds EX and forwarding
//   stall                      combinational; freezes PC and IF/ID
//   hz_state                   debug state: 0 RUN, 1 BUBBLE, 2 HOLD
//   stall_cycles               saturating count of cycles with stall=1
// -----------------------------------------------------------------------------
module id_ex_hazard_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             ex_busy,
  input  logic             flush,
  output logic             id_ex_valid,
  output logic             id_ex_reg_write,
  output logic             id_ex_mem_read,
  output logic             id_ex_mem_write,
  output logic [6:0]       id_ex_opcode,
  output logic [4:0]       id_ex_rs1,
  output logic [4:0]       id_ex_rs2,
  output logic [4:0]       id_ex_rd,
  output logic [XLEN-1:0]  id_ex_pc,
  output logic [XLEN-1:0]  id_ex_rs1_data,
  output logic [XLEN-1:0]  id_ex_rs2_data,
  output logic [XLEN-1:0]  id_ex_imm,
  output logic             stall,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2
  } hz_state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  hz_state_t state_q, state_d;
  logic      uses_rs1, uses_rs2, load_use;

  // Decide which source fields are real register reads. The rs1/rs2 bit
  // fields of other formats hold immediate bits and must not cause a stall.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    if (id_opcode == OP_JAL || id_opcode == OP_LUI || id_opcode == OP_AUIPC)
      uses_rs1 = 1'b0;
    if (id_opcode == OP_R || id_opcode == OP_STORE || id_opcode == OP_BRANCH)
      uses_rs2 = 1'b1;
  end

  // A bubble has mem_read=0, so it cannot trigger this again. After a HOLD the
  // held load is still in ID/EX, so the check runs again in the release cycle.
  assign load_use = id_valid && id_ex_valid && id_ex_mem_read &&
                    (id_ex_rd != 5'd0) &&
                    (((id_ex_rd == id_rs1) && uses_rs1) ||
                     ((id_ex_rd == id_rs2) && uses_rs2));

  // Gated by rst_n so a busy FPU cannot hold the front end while in reset.
  assign stall = rst_n && !flush && (ex_busy || load_use);

  always_comb begin
    state_d = RUN;
    if (flush)         state_d = RUN;
    else if (ex_busy)  state_d = HOLD;
    else if (load_use) state_d = BUBBLE;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign hz_state = state_q;

  // Control fields: cleared by a flush or a bubble, frozen while EX is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_valid     <= 1'b0;
      id_ex_reg_write <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_mem_write <= 1'b0;
      id_ex_opcode    <= 7'd0;
      id_ex_rd        <= 5'd0;
    end else if (flush || (!ex_busy && load_use)) begin
      id_ex_valid     <= 1'b0;
      id_ex_reg_write <= 1'b0;
      id_ex_mem_read  <= 1'b0;
      id_ex_mem_write <= 1'b0;
      id_ex_opcode    <= 7'd0;
      id_ex_rd        <= 5'd0;
    end else if (!ex_busy) begin
      id_ex_valid     <= id_valid;
      id_ex_reg_write <= id_reg_write;
      id_ex_mem_read  <= id_mem_read;
      id_ex_mem_write <= id_mem_write;
      id_ex_opcode    <= id_opcode;
      id_ex_rd        <= id_rd;
    end
  end

  // Data fields: loaded only on a normal capture, so they do not toggle on
  // bubbles or flushes.
  // NOTE: these plain flops are reset on purpose; downstream may sample them
  // before the first valid instruction, so they must start at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_rs1      <= 5'd0;
      id_ex_rs2      <= 5'd0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
    end else if (!flush && !ex_busy && !load_use) begin
      id_ex_rs1      <= id_rs1;
      id_ex_rs2      <= id_rs2;
      id_ex_pc       <= id_pc;
      id_ex_rs1_data <= id_rs1_data;
      id_ex_rs2_data <= id_rs2_data;
      id_ex_imm      <= id_imm;
    end
  end

  // Counter stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
module tb_id_ex_hazard_stage;

  logic        clk, rst_n;
  logic        id_valid, id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_busy, flush;
  logic        id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic [6:0]  id_ex_opcode;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic        stall;
  logic [1:0]  hz_state;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_hazard_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .ex_busy(ex_busy), .flush(flush),
    .id_ex_valid(id_ex_valid), .id_ex_reg_write(id_ex_reg_write),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
    .id_ex_opcode(id_ex_opcode), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
    .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm), .stall(stall),
    .hz_state(hz_state), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LOAD = 7'b0000011, OPR = 7'b0110011, OPI = 7'b0010011,
                         STORE = 7'b0100011, BRANCH = 7'b1100011,
                         LUI = 7'b0110111, AUIPC = 7'b0010111,
                         JAL = 7'b1101111, JALR = 7'b1100111;

  // Reference model: the architectural content of the ID/EX slot.
  typedef struct {
    logic        valid, rw, mr, mw;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, d1, d2, imm;
    logic [1:0]  st;
    logic [15:0] cnt;
  } model_t;
  model_t m;

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == JAL || op == LUI || op == AUIPC);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == OPR || op == STORE || op == BRANCH);
  endfunction

  function automatic bit m_hazard();
    return id_valid && m.valid && m.mr && (m.rd != 0) &&
           ((m.rd == id_rs1 && reads_rs1(id_opcode)) ||
            (m.rd == id_rs2 && reads_rs2(id_opcode)));
  endfunction

  function automatic bit m_stall();
    return !flush && (ex_busy || m_hazard());
  endfunction

  function automatic logic [171:0] model_vec();
    return {m.valid, m.rw, m.mr, m.mw, m.op, m.rs1, m.rs2, m.rd,
            m.pc, m.d1, m.d2, m.imm, m.st, m.cnt};
  endfunction

  function automatic logic [171:0] dut_vec();
    return {id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
            id_ex_opcode, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_pc,
            id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, hz_state, stall_cycles};
  endfunction

  task automatic model_reset();
    m = '{valid: 0, rw: 0, mr: 0, mw: 0, op: 0, rs1: 0, rs2: 0, rd: 0,
          pc: 0, d1: 0, d2: 0, imm: 0, st: 0, cnt: 0};
  endtask

  // One clock edge; the model takes the same step. Ends 1 time unit after
  // the edge, so the outputs are sampled away from the clock edge.
  task automatic tick();
    bit hz, st;
    hz = m_hazard();
    st = m_stall();
    @(posedge clk);
    if (st && m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
    if (flush || (!ex_busy && hz)) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.op = 0; m.rd = 0;
      m.st = flush ? 2'd0 : 2'd1;
    end else if (ex_busy) begin
      m.st = 2'd2;
    end else begin
      m.valid = id_valid; m.rw = id_reg_write; m.mr = id_mem_read;
      m.mw = id_mem_write; m.op = id_opcode; m.rs1 = id_rs1; m.rs2 = id_rs2;
      m.rd = id_rd; m.pc = id_pc; m.d1 = id_rs1_data; m.d2 = id_rs2_data;
      m.imm = id_imm; m.st = 2'd0;
    end
    #1;
  endtask

  task automatic present(input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] pc);
    id_valid = 1; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_pc = pc; id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm = $urandom;
    id_mem_read = (op == LOAD); id_mem_write = (op == STORE);
    id_reg_write = !(op == STORE || op == BRANCH);
  endtask

  task automatic test_reset();
    ex_busy = 1; flush = 0;
    present(LOAD, 5, 1, 2, 32'h40);
    #3;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall: got %b want 0", stall);
    end
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    @(posedge clk); #1;
    rst_n = 1; ex_busy = 0; id_valid = 0;
    model_reset();
  endtask

  task automatic test_load_use();
    present(LOAD, 5, 1, 2, 32'h80);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL lu_first_stall: got %b want 0", stall);
    end
    tick();
    present(OPR, 6, 5, 7, 32'h84);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL lu_stall: got %b want 1", stall);
    end
    tick();
    n_cmp++;
    if ({id_ex_valid, id_ex_opcode, hz_state, stall_cycles} !== {1'b0, 7'd0, 2'd1, 16'd1}) begin
      n_bad++;
      $display("FAIL lu_bubble: got v=%b op=%h st=%0d cnt=%0d want v=0 op=0 st=1 cnt=1",
               id_ex_valid, id_ex_opcode, hz_state, stall_cycles);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL lu_single_bubble: got %b want 0", stall);
    end
    tick();
    n_cmp++;
    if ({id_ex_valid, id_ex_opcode, id_ex_rs1, hz_state, stall_cycles} !==
        {1'b1, OPR, 5'd5, 2'd0, 16'd1}) begin
      n_bad++;
      $display("FAIL lu_capture: got v=%b op=%h rs1=%0d st=%0d cnt=%0d want v=1 op=33 rs1=5 st=0 cnt=1",
               id_ex_valid, id_ex_opcode, id_ex_rs1, hz_state, stall_cycles);
    end
  endtask

  task automatic test_non_consumers();
    logic [6:0] ops [4] = '{OPR, LUI, JAL, OPI};
    logic [4:0] lds [4] = '{5'd0, 5'd5, 5'd5, 5'd5};
    logic [4:0] r1s [4] = '{5'd0, 5'd5, 5'd5, 5'd1};
    logic [4:0] r2s [4] = '{5'd0, 5'd5, 5'd5, 5'd5};
    for (int i = 0; i < 4; i++) begin
      present(LOAD, lds[i], 1, 2, 32'h100 + 8 * i);
      tick();
      present(ops[i], 9, r1s[i], r2s[i], 32'h104 + 8 * i);
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin
        n_bad++; $display("FAIL non_consumer_%0d: stall got %b want 0", i, stall);
      end
      tick();
    end
  endtask

  task automatic test_fpu_hold();
    logic [15:0] c0;
    present(OPR, 3, 1, 2, 32'hFC);
    tick();
    c0 = stall_cycles;
    for (int i = 0; i < 4; i++) begin
      present(OPR, 4, 1, 2, 32'h100);
      ex_busy = 1;
      #1;
      n_cmp++;
      if (stall !== 1'b1) begin
        n_bad++; $display("FAIL hold_stall_%0d: got %b want 1", i, stall);
      end
      tick();
      n_cmp++;
      if ({hz_state, id_ex_pc, id_ex_rd} !== {2'd2, 32'hFC, 5'd3}) begin
        n_bad++;
        $display("FAIL hold_frozen_%0d: got st=%0d pc=%h rd=%0d want st=2 pc=fc rd=3",
                 i, hz_state, id_ex_pc, id_ex_rd);
      end
    end
    n_cmp++;
    if (stall_cycles !== c0 + 16'd4) begin
      n_bad++; $display("FAIL hold_count: got %0d want %0d", stall_cycles, c0 + 16'd4);
    end
    ex_busy = 0;
    tick();
    n_cmp++;
    if ({id_ex_valid, id_ex_pc, hz_state} !== {1'b1, 32'h100, 2'd0}) begin
      n_bad++;
      $display("FAIL hold_release: got v=%b pc=%h st=%0d want v=1 pc=100 st=0",
               id_ex_valid, id_ex_pc, hz_state);
    end
  endtask

  task automatic test_flush_priority();
    logic [31:0] d_old;
    logic [15:0] c0;
    present(LOAD, 5, 1, 2, 32'h200);
    tick();
    d_old = id_ex_rs1_data;
    c0 = stall_cycles;
    present(OPR, 6, 5, 5, 32'h204);
    ex_busy = 1; flush = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL flush_stall: got %b want 0", stall);
    end
    tick();
    n_cmp++;
    if ({id_ex_valid, id_ex_opcode, id_ex_rd, hz_state, id_ex_rs1_data, stall_cycles} !==
        {1'b0, 7'd0, 5'd0, 2'd0, d_old, c0}) begin
      n_bad++;
      $display("FAIL flush_prio: got v=%b op=%h rd=%0d st=%0d d1=%h cnt=%0d want v=0 op=0 rd=0 st=0 d1=%h cnt=%0d",
               id_ex_valid, id_ex_opcode, id_ex_rd, hz_state, id_ex_rs1_data,
               stall_cycles, d_old, c0);
    end
    ex_busy = 0; flush = 0;
  endtask

  task automatic test_random();
    logic [6:0] pool [9] = '{LOAD, OPR, OPI, STORE, BRANCH, LUI, AUIPC, JAL, JALR};
    for (int i = 0; i < 400; i++) begin
      present(pool[$urandom_range(8)], 5'($urandom_range(7)),
              5'($urandom_range(7)), 5'($urandom_range(7)), $urandom);
      id_valid = ($urandom_range(9) != 0);
      ex_busy  = ($urandom_range(4) == 0);
      flush    = ($urandom_range(9) == 0);
      #1;
      n_cmp++;
      if (stall !== m_stall()) begin
        n_bad++; $display("FAIL rand_stall_%0d: got %b want %b", i, stall, m_stall());
      end
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++; $display("FAIL rand_state_%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    ex_busy = 0; flush = 0;
  endtask

  task automatic test_saturation();
    ex_busy = 1;
    for (int i = 0; i < 70000; i++) tick();
    n_cmp++;
    if (stall_cycles !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_count: got %h want ffff", stall_cycles);
    end
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++; $display("FAIL sat_state: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_reset_mid_hold();
    // ex_busy is still high, so the stage is in HOLD here.
    #3 rst_n = 0;
    #1;
    n_cmp++;
    if ({dut_vec(), stall} !== '0) begin
      n_bad++; $display("FAIL reset_mid_hold: got %h stall=%b want 0", dut_vec(), stall);
    end
    model_reset();
    @(posedge clk); #1;
    ex_busy = 0; id_valid = 0; rst_n = 1;
    tick();
    n_cmp++;
    if ({hz_state, stall_cycles, stall} !== '0) begin
      n_bad++;
      $display("FAIL reset_release: got st=%0d cnt=%0d stall=%b want 0",
               hz_state, stall_cycles, stall);
    end
  endtask

  initial begin
    rst_n = 0; id_valid = 0; id_opcode = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    ex_busy = 0; flush = 0;
    model_reset();
    test_reset();
    test_load_use();
    test_non_consumers();
    test_fpu_hold();
    test_flush_priority();
    test_random();
    test_saturation();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
